// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot occupancy scheduler.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } sched_state_t;

  typedef enum logic {
    SRC_INC,
    SRC_DEC
  } src_t;

  localparam int MAX_BCD_COUNT = 99;
  localparam int OCC_W         = 7;

  // Round-robin between the two event sources; a lone pending source always wins.
  function automatic src_t pick_source(input logic ent_pending,
                                       input logic ext_pending,
                                       input src_t last_served);
    if (ent_pending && ext_pending) begin
      return (last_served == SRC_INC) ? SRC_DEC : SRC_INC;
    end else if (ext_pending) begin
      return SRC_DEC;
    end else begin
      return SRC_INC;
    end
  endfunction

endpackage

// File: rtl/sat_updown.sv
// Saturating pending-event counter: counts detector pulses up, scheduler consumes down.
module sat_updown #(
  parameter int PEND_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic sat_drop
);

  localparam logic [PEND_W-1:0] MAX_COUNT = '1;

  logic [PEND_W-1:0] count_q;
  logic [PEND_W-1:0] count_d;
  logic              dec_ok;

  // An event and a consume in the same cycle cancel, so saturation only drops a lone event.
  always_comb begin
    count_d  = count_q;
    sat_drop = 1'b0;
    dec_ok   = dec && (count_q != '0);
    case ({inc, dec_ok})
      2'b10: begin
        if (count_q == MAX_COUNT) begin
          sat_drop = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign nonzero = (count_q != '0);

endmodule

// File: rtl/occupancy_sched.sv
// Arbitrates entry/exit events into one-at-a-time inc/dec commands for the BCD counter
// and keeps a binary shadow of the committed occupancy with full/empty flags.
module occupancy_sched
  import parking_pkg::*;
#(
  parameter int CAPACITY = 99,
  parameter int PEND_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent_evt,
  input  logic             ext_evt,
  input  logic             cnt_ready,
  output logic             cnt_inc,
  output logic             cnt_dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             underflow,
  output logic             lost_evt
);

  localparam int               CAP_EFF = (CAPACITY > MAX_BCD_COUNT) ? MAX_BCD_COUNT : CAPACITY;
  localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAP_EFF);

  sched_state_t     state_q, state_d;
  src_t             last_served_q, last_served_d;
  src_t             cand;
  logic             cnt_inc_q, cnt_inc_d;
  logic             cnt_dec_q, cnt_dec_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             reject_q, reject_d;
  logic             underflow_q, underflow_d;
  logic             lost_evt_q, lost_evt_d;

  logic ent_consume, ext_consume;
  logic ent_pending, ext_pending;
  logic ent_drop, ext_drop;

  sat_updown #(.PEND_W(PEND_W)) u_pend_ent (
    .clk      (clk),
    .reset    (reset),
    .inc      (ent_evt),
    .dec      (ent_consume),
    .nonzero  (ent_pending),
    .sat_drop (ent_drop)
  );

  sat_updown #(.PEND_W(PEND_W)) u_pend_ext (
    .clk      (clk),
    .reset    (reset),
    .inc      (ext_evt),
    .dec      (ext_consume),
    .nonzero  (ext_pending),
    .sat_drop (ext_drop)
  );

  // Discards consume a pending event but leave the counter untouched and stay in IDLE.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    cnt_inc_d     = cnt_inc_q;
    cnt_dec_d     = cnt_dec_q;
    occupancy_d   = occupancy_q;
    reject_d      = 1'b0;
    underflow_d   = 1'b0;
    ent_consume   = 1'b0;
    ext_consume   = 1'b0;
    cand          = pick_source(ent_pending, ext_pending, last_served_q);

    case (state_q)
      IDLE: begin
        if (ent_pending || ext_pending) begin
          if (cand == SRC_INC) begin
            ent_consume = 1'b1;
            if (full_q) begin
              reject_d = 1'b1;
            end else begin
              cnt_inc_d     = 1'b1;
              last_served_d = SRC_INC;
              state_d       = ISSUE;
            end
          end else begin
            ext_consume = 1'b1;
            if (empty_q) begin
              underflow_d = 1'b1;
            end else begin
              cnt_dec_d     = 1'b1;
              last_served_d = SRC_DEC;
              state_d       = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (cnt_ready) begin
          cnt_inc_d = 1'b0;
          cnt_dec_d = 1'b0;
          if (cnt_inc_q) begin
            occupancy_d = occupancy_q + 7'd1;
          end else if (cnt_dec_q) begin
            occupancy_d = occupancy_q - 7'd1;
          end
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    full_d     = (occupancy_d == CAP_OCC);
    empty_d    = (occupancy_d == '0);
    lost_evt_d = ent_drop | ext_drop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= SRC_DEC;
      cnt_inc_q     <= 1'b0;
      cnt_dec_q     <= 1'b0;
      occupancy_q   <= '0;
      full_q        <= (CAP_EFF == 0);
      empty_q       <= 1'b1;
      reject_q      <= 1'b0;
      underflow_q   <= 1'b0;
      lost_evt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      cnt_inc_q     <= cnt_inc_d;
      cnt_dec_q     <= cnt_dec_d;
      occupancy_q   <= occupancy_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      reject_q      <= reject_d;
      underflow_q   <= underflow_d;
      lost_evt_q    <= lost_evt_d;
    end
  end

  assign cnt_inc   = cnt_inc_q;
  assign cnt_dec   = cnt_dec_q;
  assign occupancy = occupancy_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign reject    = reject_q;
  assign underflow = underflow_q;
  assign lost_evt  = lost_evt_q;

  a_cmd_exclusive: assert property (@(posedge clk) !(cnt_inc_q && cnt_dec_q));

endmodule

// File: tb/tb_occupancy_sched.sv
// Self-checking bench for occupancy_sched: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_occupancy_sched;

  localparam int CAP      = 6;
  localparam int PEND_W   = 3;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ent_evt = 1'b0;
  logic       ext_evt = 1'b0;
  logic       cnt_ready = 1'b1;
  logic       cnt_inc, cnt_dec, full, empty, reject, underflow, lost_evt;
  logic [6:0] occupancy;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int m_pend_ent = 0, m_pend_ext = 0, m_occ = 0;
  int m_cmd = 0;          // 0 none, 1 inc, 2 dec
  bit m_gap = 0, m_last_inc = 0;
  bit m_reject = 0, m_under = 0, m_lost = 0;
  int m_ent_use, m_ext_use, m_nxt;
  bit m_take_inc;

  occupancy_sched #(.CAPACITY(CAP), .PEND_W(PEND_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ent_evt   (ent_evt),
    .ext_evt   (ext_evt),
    .cnt_ready (cnt_ready),
    .cnt_inc   (cnt_inc),
    .cnt_dec   (cnt_dec),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .reject    (reject),
    .underflow (underflow),
    .lost_evt  (lost_evt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic x);
    @(negedge clk);
    ent_evt = e;
    ext_evt = x;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  // Event-level model: one command in flight, a one-cycle gap after each acceptance,
  // round-robin among pending sources, capacity and non-negative limits enforced by discarding.
  always @(posedge clk) begin
    if (!reset) begin
      m_pend_ent = 0; m_pend_ext = 0; m_occ = 0; m_cmd = 0; m_gap = 0;
      m_last_inc = 0; m_reject = 0; m_under = 0; m_lost = 0;
    end else begin
      m_ent_use = 0; m_ext_use = 0; m_reject = 0; m_under = 0; m_lost = 0;
      if (m_cmd != 0) begin
        if (cnt_ready) begin
          m_occ = (m_cmd == 1) ? m_occ + 1 : m_occ - 1;
          m_cmd = 0;
          m_gap = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (m_pend_ent > 0 || m_pend_ext > 0) begin
        m_take_inc = (m_pend_ent > 0) && (m_pend_ext == 0 || !m_last_inc);
        if (m_take_inc) begin
          m_ent_use = 1;
          if (m_occ == CAP) m_reject = 1;
          else begin m_cmd = 1; m_last_inc = 1; end
        end else begin
          m_ext_use = 1;
          if (m_occ == 0) m_under = 1;
          else begin m_cmd = 2; m_last_inc = 0; end
        end
      end
      m_nxt = m_pend_ent + int'(ent_evt) - m_ent_use;
      if (m_nxt > PEND_MAX) begin m_nxt = PEND_MAX; m_lost = 1; end
      m_pend_ent = m_nxt;
      m_nxt = m_pend_ext + int'(ext_evt) - m_ext_use;
      if (m_nxt > PEND_MAX) begin m_nxt = PEND_MAX; m_lost = 1; end
      m_pend_ext = m_nxt;
    end
  end

  always @(negedge clk) begin
    checkOutput("cnt_inc",   cnt_inc,   m_cmd == 1);
    checkOutput("cnt_dec",   cnt_dec,   m_cmd == 2);
    checkOutput("occupancy", occupancy, m_occ);
    checkOutput("full",      full,      m_occ == CAP);
    checkOutput("empty",     empty,     m_occ == 0);
    checkOutput("reject",    reject,    m_reject);
    checkOutput("underflow", underflow, m_under);
    checkOutput("lost_evt",  lost_evt,  m_lost);
  end

  initial begin
    int lost_seen;
    bit any_cmd;

    // reset values
    idle(2);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_cnt_inc", cnt_inc, 0);
    reset = 1'b1;
    idle(2);

    // single entry: command high two cycles after the pulse, occupancy one cycle later
    $display("[TB] single entry");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_inc_t1", cnt_inc, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_inc_t2", cnt_inc, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_inc_t3", cnt_inc, 0);
    checkOutput("single_occ_t3", occupancy, 1);
    checkOutput("single_empty_t3", empty, 0);
    idle(3);

    // fill to capacity, then one exit so the last served source is DEC
    repeat (5) applyStimulus(1'b1, 1'b0);
    idle(20);
    checkOutput("fill_occ", occupancy, 6);
    checkOutput("fill_full", full, 1);
    applyStimulus(1'b0, 1'b1);
    idle(6);
    checkOutput("exit_occ", occupancy, 5);

    // simultaneous entry and exit at 5: inc first, dec after the gap
    $display("[TB] simultaneous events");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_inc_first", cnt_inc, 1);
    checkOutput("tie_dec_not_yet", cnt_dec, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_occ_6", occupancy, 6);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_dec_second", cnt_dec, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_occ_5", occupancy, 5);
    idle(3);

    // entry while full is rejected
    $display("[TB] reject when full");
    applyStimulus(1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reject_pulse", reject, 1);
    checkOutput("reject_no_inc", cnt_inc, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reject_one_cycle", reject, 0);
    checkOutput("reject_occ", occupancy, 6);
    idle(2);

    // drain to zero, then an exit underflows
    $display("[TB] underflow when empty");
    repeat (6) applyStimulus(1'b0, 1'b1);
    idle(20);
    checkOutput("drain_occ", occupancy, 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("underflow_pulse", underflow, 1);
    checkOutput("underflow_no_dec", cnt_dec, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("underflow_one_cycle", underflow, 0);
    checkOutput("underflow_occ", occupancy, 0);
    idle(2);

    // stalled counter: pending entries saturate at 7, two arrivals are lost
    $display("[TB] stall and saturation");
    cnt_ready = 1'b0;
    lost_seen = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 10, 1'b0);
      lost_seen += int'(lost_evt);
      if (i >= 2) checkOutput("stall_hold_inc", cnt_inc, 1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("stall_lost_count", lost_seen, 2);
    checkOutput("stall_still_inc", cnt_inc, 1);
    cnt_ready = 1'b1;
    idle(30);
    checkOutput("stall_drain_occ", occupancy, 6);
    checkOutput("stall_drain_full", full, 1);

    // reset while a command is in flight with four entries pending
    $display("[TB] reset during issue");
    repeat (3) applyStimulus(1'b0, 1'b1);
    idle(12);
    checkOutput("pre_reset_occ", occupancy, 3);
    cnt_ready = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pre_reset_inc", cnt_inc, 1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_inc_cleared", cnt_inc, 0);
    checkOutput("reset_occ", occupancy, 0);
    checkOutput("reset_empty", empty, 1);
    reset = 1'b1;
    cnt_ready = 1'b1;
    any_cmd = 1'b0;
    repeat (12) begin
      applyStimulus(1'b0, 1'b0);
      any_cmd |= (cnt_inc | cnt_dec);
    end
    checkOutput("post_reset_no_cmd", any_cmd, 0);
    checkOutput("post_reset_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
